alu_add_sequencer: RTL and testbench

- Nibble-serial front/back end for the 8-bit ripple adder (two 4-bit adders chained through an internal carry) in the ALU datapath.
- Upstream: loads operands A and B over a 4-bit valid/ready bus, selects add or subtract, and drives the adder's A, B and C_in.
- Downstream: captures S and C_out, derives status flags, and streams the result back out nibble-serially with valid/ready backpressure.
- Sized for the limited pin budget of the top-level wrapper.

---
 rtl/alu_add_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_add_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_add_sequencer.sv
// Nibble-serial operand loader and result streamer around an external 8-bit adder.
// Define ALU_FLAGS_EN to add the {N,Z,V,C} status beat after the two sum nibbles.
module alu_add_sequencer #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic       op_sub,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_cin,
  input  logic [7:0] add_s,
  input  logic       add_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data
);

  typedef enum logic [2:0] {
    LD_A_LO,
    LD_A_HI,
    LD_B_LO,
    LD_B_HI,
    EXEC,
    OUT_S_LO,
`ifdef ALU_FLAGS_EN
    OUT_S_HI,
    OUT_FLAGS
`else
    OUT_S_HI
`endif
  } state_t;

  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

  state_t     state, next_state;
  logic [7:0] a_q, b_q, s_q;
  logic       sub_q;
  logic [3:0] cnt;
  logic       in_xfer;

`ifdef ALU_FLAGS_EN
  logic [3:0] flags_q;

  function automatic logic [3:0] calc_flags(input logic [7:0] a, input logic [7:0] beff,
                                            input logic [7:0] s, input logic cout);
    logic n, z, v;
    n = s[7];
    z = (s == 8'h00);
    v = (a[7] == beff[7]) && (s[7] != a[7]);
    return {n, z, v, cout};
  endfunction
`else
  wire unused_cout = add_cout;
`endif

  // Subtract is A + ~B + 1, so the adder sees inverted B and the latched op as carry-in.
  assign add_a   = a_q;
  assign add_b   = b_q ^ {8{sub_q}};
  assign add_cin = sub_q;
  assign in_xfer = in_valid && in_ready;

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = 4'h0;
    case (state)
      LD_A_LO: begin
        in_ready = 1'b1;
        if (in_valid) next_state = LD_A_HI;
      end
      LD_A_HI: begin
        in_ready = 1'b1;
        if (in_valid) next_state = LD_B_LO;
      end
      LD_B_LO: begin
        in_ready = 1'b1;
        if (in_valid) next_state = LD_B_HI;
      end
      LD_B_HI: begin
        in_ready = 1'b1;
        if (in_valid) next_state = EXEC;
      end
      EXEC: begin
        if (cnt == EXEC_LAST) next_state = OUT_S_LO;
      end
      OUT_S_LO: begin
        out_valid = 1'b1;
        out_data  = s_q[3:0];
        if (out_ready) next_state = OUT_S_HI;
      end
      OUT_S_HI: begin
        out_valid = 1'b1;
        out_data  = s_q[7:4];
`ifdef ALU_FLAGS_EN
        if (out_ready) next_state = OUT_FLAGS;
`else
        if (out_ready) next_state = LD_A_LO;
`endif
      end
`ifdef ALU_FLAGS_EN
      OUT_FLAGS: begin
        out_valid = 1'b1;
        out_data  = flags_q;
        if (out_ready) next_state = LD_A_LO;
      end
`endif
      default: next_state = LD_A_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LD_A_LO;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      s_q     <= 8'h00;
      sub_q   <= 1'b0;
      cnt     <= 4'h0;
`ifdef ALU_FLAGS_EN
      flags_q <= 4'h0;
`endif
    end else begin
      state <= next_state;
      case (state)
        LD_A_LO: if (in_xfer) begin
          a_q[3:0] <= in_data;
          sub_q    <= op_sub;
        end
        LD_A_HI: if (in_xfer) a_q[7:4] <= in_data;
        LD_B_LO: if (in_xfer) b_q[3:0] <= in_data;
        LD_B_HI: if (in_xfer) begin
          b_q[7:4] <= in_data;
          cnt      <= 4'h0;
        end
        EXEC: begin
          cnt <= cnt + 4'd1;
          // Adder inputs have been stable for EXEC_CYCLES cycles by this edge.
          if (cnt == EXEC_LAST) begin
            s_q     <= add_s;
`ifdef ALU_FLAGS_EN
            flags_q <= calc_flags(a_q, add_b, add_s, add_cout);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_add_sequencer.sv
// Scoreboard bench for alu_add_sequencer with a behavioural 8-bit adder on the adder ports.
module tb_alu_add_sequencer;

  localparam int EXEC = 3;
`ifdef ALU_FLAGS_EN
  localparam int NBEATS = 3;
`else
  localparam int NBEATS = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = 4'h0;
  logic       op_sub = 1'b0;
  logic [7:0] add_a, add_b, add_s;
  logic       add_cin, add_cout;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_data;

  int total = 0;
  int bad = 0;
  logic [3:0] sb_q[$];

  always #5 clk = ~clk;

  always_comb {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

  alu_add_sequencer #(.EXEC_CYCLES(EXEC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .op_sub(op_sub), .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s),
    .add_cout(add_cout), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // Reference result computed from integer arithmetic on the operands.
  task automatic push_expected(input logic [7:0] a, input logic [7:0] b, input logic sub);
    int ua, ub, sa, sbv, r, sr;
    logic [7:0] s;
    logic n, z, v, c;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sbv = int'($signed(b));
    r  = sub ? ua - ub : ua + ub;
    sr = sub ? sa - sbv : sa + sbv;
    s  = 8'(r);
    n  = s[7];
    z  = (s == 8'h00);
    v  = (sr > 127) || (sr < -128);
    c  = sub ? (ua >= ub) : (r > 255);
    sb_q.push_back(s[3:0]);
    sb_q.push_back(s[7:4]);
    if (NBEATS == 3) sb_q.push_back({n, z, v, c});
  endtask

  task automatic send_nibble(input logic [3:0] d, input logic sub, input int gap);
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = d; op_sub = sub;
    for (int i = 0; i < 50 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_op(input logic [7:0] a, input logic [7:0] b, input logic sub, input int gap);
    push_expected(a, b, sub);
    send_nibble(a[3:0], sub, 0);
    send_nibble(a[7:4], 1'b0, gap);
    send_nibble(b[3:0], 1'b0, gap);
    send_nibble(b[7:4], 1'b0, gap);
  endtask

  task automatic get_beat(output logic [3:0] d, output bit ok);
    ok = 1'b0; d = 4'h0; out_ready = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (out_valid) begin
        d = out_data; ok = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 4'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    total++; if ({add_a, add_b, add_cin} !== 17'h0) begin bad++; $display("FAIL reset_adder got=%h/%h/%b want=00/00/0", add_a, add_b, add_cin); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_add_overflow;
    logic [3:0] d, e; bit ok; int lat;
    send_op(8'h3C, 8'h45, 1'b0, 0);
    total++; if ({add_a, add_b, add_cin} !== {8'h3C, 8'h45, 1'b0}) begin bad++; $display("FAIL add_drive got=%h/%h/%b want=3c/45/0", add_a, add_b, add_cin); end
    lat = 1;
    for (int i = 0; i < 40 && !out_valid; i++) begin
      @(posedge clk); #1; lat++;
    end
    total++; if (lat !== EXEC + 1) begin bad++; $display("FAIL add_latency got=%0d want=%0d", lat, EXEC + 1); end
    for (int i = 0; i < NBEATS; i++) begin
      get_beat(d, ok); e = sb_q.pop_front();
      total++; if (!ok || d !== e) begin bad++; $display("FAIL add_beat%0d got=%h ok=%0d want=%h", i, d, ok, e); end
    end
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL add_return got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_sub_zero;
    logic [3:0] d, e; bit ok;
    send_op(8'h10, 8'h10, 1'b1, 0);
    total++; if ({add_b, add_cin} !== {8'hEF, 1'b1}) begin bad++; $display("FAIL sub_drive got=%h/%b want=ef/1", add_b, add_cin); end
    for (int i = 0; i < NBEATS; i++) begin
      get_beat(d, ok); e = sb_q.pop_front();
      total++; if (!ok || d !== e) begin bad++; $display("FAIL sub_beat%0d got=%h ok=%0d want=%h", i, d, ok, e); end
    end
  endtask

  task automatic test_wrap;
    logic [3:0] d, e; bit ok;
    send_op(8'hFF, 8'h01, 1'b0, 0);
    for (int i = 0; i < NBEATS; i++) begin
      get_beat(d, ok); e = sb_q.pop_front();
      total++; if (!ok || d !== e) begin bad++; $display("FAIL wrap_beat%0d got=%h ok=%0d want=%h", i, d, ok, e); end
    end
  endtask

  task automatic test_backpressure;
    logic [3:0] d, e; bit ok;
    send_op(8'h3C, 8'h45, 1'b0, 3);
    get_beat(d, ok); e = sb_q.pop_front();
    total++; if (!ok || d !== e) begin bad++; $display("FAIL bp_beat0 got=%h ok=%0d want=%h", d, ok, e); end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || out_data !== sb_q[0]) begin bad++; $display("FAIL bp_hold%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, sb_q[0]); end
    end
    for (int i = 1; i < NBEATS; i++) begin
      get_beat(d, ok); e = sb_q.pop_front();
      total++; if (!ok || d !== e) begin bad++; $display("FAIL bp_beat%0d got=%h ok=%0d want=%h", i, d, ok, e); end
    end
  endtask

  task automatic test_reset_mid_load;
    logic [3:0] d, e; bit ok;
    send_nibble(4'h7, 1'b1, 0);
    send_nibble(4'h9, 1'b0, 0);
    #2; rst_n = 1'b0; #1;
    total++; if ({out_valid, out_data, add_a, add_b, add_cin} !== 22'h0) begin bad++; $display("FAIL midrst_zero got v=%b d=%h a=%h b=%h c=%b want all 0", out_valid, out_data, add_a, add_b, add_cin); end
    @(posedge clk); #1; rst_n = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    send_op(8'h01, 8'h02, 1'b0, 0);
    for (int i = 0; i < NBEATS; i++) begin
      get_beat(d, ok); e = sb_q.pop_front();
      total++; if (!ok || d !== e) begin bad++; $display("FAIL midrst_beat%0d got=%h ok=%0d want=%h", i, d, ok, e); end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] d, e; bit ok; logic [7:0] a, b; logic s;
    for (int k = 0; k < 6; k++) begin
      a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); s = 1'($urandom_range(0, 1));
      if (k == 0) begin a = 8'h80; b = 8'h80; s = 1'b0; end
      if (k == 1) begin a = 8'h00; b = 8'h80; s = 1'b1; end
      send_op(a, b, s, k % 2);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_busy%0d in_ready got=%b want=0", k, in_ready); end
      for (int i = 0; i < NBEATS; i++) begin
        get_beat(d, ok); e = sb_q.pop_front();
        total++; if (!ok || d !== e) begin bad++; $display("FAIL b2b_op%0d_beat%0d a=%h b=%h sub=%b got=%h ok=%0d want=%h", k, i, a, b, s, d, ok, e); end
      end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle%0d in_ready got=%b want=1", k, in_ready); end
    end
  endtask

  initial begin
    test_reset;
    test_add_overflow;
    test_sub_zero;
    test_wrap;
    test_backpressure;
    test_reset_mid_load;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
